fir_out_arbiter: RTL and testbench
==================================

FIR_OUT_ARBITER -- requirements
Module: fir_out_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of FIR result streams merged.
REQ-002 SHALL have parameter DATA_SIZE, default 32, sample width in bits.
REQ-003 SHALL have parameter CNT_SIZE, default 16, per-channel sample counter width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports: clock  input  1  rising-edge clock; reset  input  1  async active-high reset.
REQ-005 SHALL have port x_in  input  NUM_CH*DATA_SIZE  first-word-fall-through FIFO heads; channel c occupies bits [c*DATA_SIZE +: DATA_SIZE].
REQ-006 SHALL have port x_empty  input  NUM_CH  per-channel FIFO empty.
REQ-007 SHALL have port x_rd_en  output  NUM_CH  per-channel pop, one-hot or zero.
REQ-008 SHALL have port y_out  output  DATA_SIZE  merged sample.
REQ-009 SHALL have port y_ch  output  $clog2(NUM_CH) (min 1)  channel tag of y_out.
REQ-010 SHALL have port y_out_full  input  1  downstream FIFO full.
REQ-011 SHALL have port y_wr_en  output  1  downstream push.
REQ-012 SHALL have port ch_count  output  NUM_CH*CNT_SIZE  samples forwarded per channel.

Function
REQ-013 SHALL implement states S_IDLE, S_HOLD.
REQ-014 In S_IDLE SHALL choose the first non-empty channel searching from ptr upward, modulo NUM_CH (round-robin).
REQ-015 On choice SHALL assert x_rd_en[c] combinationally same cycle, register x_in channel c into hold_data and c into hold_ch, go to S_HOLD.
REQ-016 If all channels empty in S_IDLE SHALL assert nothing and remain in S_IDLE.
REQ-017 In S_HOLD SHALL drive y_out=hold_data, y_ch=hold_ch combinationally; assert y_wr_en only when y_out_full=0.
REQ-018 On a write, SHALL set ptr=(hold_ch+1) mod NUM_CH, increment ch_count[hold_ch], return to S_IDLE.
REQ-019 While y_out_full=1 in S_HOLD SHALL hold data, tag and state unchanged; no x_rd_en asserted.
REQ-020 Throughput SHALL be one sample per 2 cycles; latency from pop to push SHALL be 1 cycle when not full.
REQ-021 ch_count SHALL wrap from 2^CNT_SIZE-1 to 0 without saturation.
REQ-022 y_out and y_ch SHALL be 0 when not in S_HOLD.
REQ-023 At most one x_rd_en bit SHALL be high per cycle; x_rd_en never asserted for an empty channel.
REQ-024 Illegal state SHALL return to S_IDLE with ptr=0.

Reset
REQ-025 reset SHALL force state=S_IDLE, ptr=0, hold_data=0, hold_ch=0, ch_count all 0.
REQ-026 During and after reset, x_rd_en=0, y_wr_en=0, y_out=0, y_ch=0 until first choice.
REQ-027 Reset in S_HOLD SHALL discard the held sample; no write issued.

Configuration
REQ-028 Macro FIR_ARB_STRICT_EN: when defined, S_IDLE SHALL consider only channel ptr, waiting while it is empty (strict lock-step interleave, e.g. L/R stereo pairing).
REQ-029 Without FIR_ARB_STRICT_EN, work-conserving round-robin per REQ-014 SHALL apply.

Verification
REQ-030 Both channels always non-empty (ch0 0x11, ch1 0x22), out never full -> outputs 0x11/ch0, 0x22/ch1 alternating, y_wr_en every 2nd cycle.
REQ-031 Only ch1 non-empty, default build -> all outputs ch1, ch_count[1] increments per write, ch_count[0]=0; strict build -> no output.
REQ-032 y_out_full=1 for 5 cycles in S_HOLD with 0xDEADBEEF held -> y_out stable, x_rd_en=0 for all 5, single write when full drops.
REQ-033 Reset asserted mid-S_HOLD -> no y_wr_en, ch_count=0, next output comes from ch0.
REQ-034 Drive 65536 ch0 samples -> ch_count[0] wraps to 0.
REQ-035 Random empty/full patterns, 10,000 cycles -> per-channel order preserved, no double pop, no pop of empty, counts match scoreboard.

Source files
------------

// File: rtl/fir_out_arbiter.sv
// fir_out_arbiter: merges NUM_CH first-word-fall-through FIR result FIFOs into
// one tagged output stream using a two-state pop/hold handshake. Each pick is
// round-robin, starting at the channel after the last one written.
// Optional macro FIR_ARB_STRICT_EN: only channel ptr is considered in S_IDLE,
// so the arbiter waits for it. This gives a strict lock-step interleave, for
// example L/R stereo pairing.
module fir_out_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int DATA_SIZE = 32,
    parameter int CNT_SIZE  = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH*DATA_SIZE-1:0]   x_in,
    input  logic [NUM_CH-1:0]             x_empty,
    output logic [NUM_CH-1:0]             x_rd_en,
    output logic [DATA_SIZE-1:0]          y_out,
    output logic [CH_W-1:0]               y_ch,
    input  logic                          y_out_full,
    output logic                          y_wr_en,
    output logic [NUM_CH*CNT_SIZE-1:0]    ch_count
);

    // One-hot encoding, so a corrupted state register is detectable.
    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [CH_W-1:0]        ptr_r;
    logic [CH_W-1:0]        hold_ch_r;
    logic [DATA_SIZE-1:0]   hold_data_r;
    logic [CH_W:0]          pick_s;
    logic                   pick_vld_s;
    logic [CH_W-1:0]        pick_ch_s;
    logic [DATA_SIZE-1:0]   pick_data_s;
    logic [DATA_SIZE-1:0]   x_data_s [NUM_CH];
    logic [CNT_SIZE-1:0]    count_r  [NUM_CH];

    // Returns {valid, channel} for the channel to pop next.
    function automatic logic [CH_W:0] pick_channel(
        input logic [NUM_CH-1:0] empty,
        input logic [CH_W-1:0]   start
    );
        logic [CH_W:0] result;
`ifdef FIR_ARB_STRICT_EN
        if (!empty[start]) begin
            result = {1'b1, start};
        end else begin
            result = {(CH_W+1){1'b0}};
        end
`else
        int idx;
        result = {(CH_W+1){1'b0}};
        // Walk from the farthest offset down, so the closest non-empty channel wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end else begin
                idx = idx;
            end
            if (!empty[idx[CH_W-1:0]]) begin
                result = {1'b1, idx[CH_W-1:0]};
            end else begin
                result = result;
            end
        end
`endif
        return result;
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign x_data_s[g]                          = x_in[g*DATA_SIZE +: DATA_SIZE];
        assign ch_count[g*CNT_SIZE +: CNT_SIZE]     = count_r[g];
    end

    assign pick_s      = pick_channel(x_empty, ptr_r);
    assign pick_vld_s  = pick_s[CH_W];
    assign pick_ch_s   = pick_s[CH_W-1:0];
    assign pick_data_s = x_data_s[pick_ch_s];

    // Next-state and handshake outputs; pops and pushes are combinational.
    always_comb begin
        state_nx_s = state_r;
        x_rd_en    = {NUM_CH{1'b0}};
        y_out      = {DATA_SIZE{1'b0}};
        y_ch       = {CH_W{1'b0}};
        y_wr_en    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (pick_vld_s && !reset) begin
                    x_rd_en    = NUM_CH'(1'b1) << pick_ch_s;
                    state_nx_s = S_HOLD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_HOLD: begin
                y_out = hold_data_r;
                y_ch  = hold_ch_r;
                if (!y_out_full) begin
                    y_wr_en    = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_HOLD;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State, pointer, held sample and per-channel counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            ptr_r       <= {CH_W{1'b0}};
            hold_ch_r   <= {CH_W{1'b0}};
            hold_data_r <= {DATA_SIZE{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                count_r[i] <= {CNT_SIZE{1'b0}};
            end
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                S_IDLE: begin
                    if (pick_vld_s) begin
                        hold_data_r <= pick_data_s;
                        hold_ch_r   <= pick_ch_s;
                    end
                end
                S_HOLD: begin
                    if (!y_out_full) begin
                        // Counters wrap freely; no saturation is wanted.
                        count_r[hold_ch_r] <= count_r[hold_ch_r] + CNT_SIZE'(1'b1);
                        if (hold_ch_r == CH_W'(NUM_CH - 1)) begin
                            ptr_r <= {CH_W{1'b0}};
                        end else begin
                            ptr_r <= hold_ch_r + CH_W'(1'b1);
                        end
                    end
                end
                default: begin
                    ptr_r <= {CH_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_out_arbiter.sv
// Self-checking bench for fir_out_arbiter (default, work-conserving build).
// A behavioural model predicts pops, pushes and counts from the arbitration
// rules, and per-channel queues check that sample order is preserved.
// CNT_SIZE is reduced to 8 so that counter wrap is reachable in a short run.
module tb_fir_out_arbiter;

    localparam int NUM_CH    = 2;
    localparam int DATA_SIZE = 32;
    localparam int CNT_SIZE  = 8;
    localparam int CH_W      = 1;
    localparam int BUS_W     = NUM_CH * DATA_SIZE;
    localparam logic [NUM_CH*CNT_SIZE-1:0] CNT_MASK = (NUM_CH*CNT_SIZE)'((1 << CNT_SIZE) - 1);

    logic                        clock;
    logic                        reset;
    logic [BUS_W-1:0]            x_in;
    logic [NUM_CH-1:0]           x_empty;
    logic [NUM_CH-1:0]           x_rd_en;
    logic [DATA_SIZE-1:0]        y_out;
    logic [CH_W-1:0]             y_ch;
    logic                        y_out_full;
    logic                        y_wr_en;
    logic [NUM_CH*CNT_SIZE-1:0]  ch_count;

    int n_cmp;
    int n_err;

    // Model state
    logic [DATA_SIZE-1:0] head [NUM_CH];
    logic [DATA_SIZE-1:0] sb   [NUM_CH][$];
    int                   m_cnt [NUM_CH];
    bit                   m_hold;
    logic [DATA_SIZE-1:0] m_data;
    int                   m_ch;
    int                   m_ptr;
    bit                   rand_heads;

    fir_out_arbiter #(
        .NUM_CH    (NUM_CH),
        .DATA_SIZE (DATA_SIZE),
        .CNT_SIZE  (CNT_SIZE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .x_in       (x_in),
        .x_empty    (x_empty),
        .x_rd_en    (x_rd_en),
        .y_out      (y_out),
        .y_ch       (y_ch),
        .y_out_full (y_out_full),
        .y_wr_en    (y_wr_en),
        .ch_count   (ch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_hold = 1'b0;
        m_data = '0;
        m_ch   = 0;
        m_ptr  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0;
            sb[i].delete();
        end
    endtask

    // One clock cycle: drive at negedge, check shortly after, advance model at posedge.
    task automatic run_cycle(input logic [NUM_CH-1:0] emp, input logic full, input logic rst);
        logic [BUS_W-1:0]  bus;
        logic [NUM_CH-1:0] exp_rd;
        logic [63:0]       exp_sb;
        bit                found;
        int                pc;
        int                c;
        bus = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (emp[i[CH_W-1:0]]) begin
                bus = bus | (BUS_W'($urandom) << (i * DATA_SIZE));
            end else begin
                bus = bus | (BUS_W'(head[i]) << (i * DATA_SIZE));
            end
        end
        reset      = rst;
        x_empty    = emp;
        y_out_full = full;
        x_in       = bus;
        if (rst) model_clear();

        // Round-robin choice: first non-empty channel at ptr, ptr+1, ... modulo NUM_CH.
        found  = 1'b0;
        pc     = 0;
        exp_rd = '0;
        if (!rst && !m_hold) begin
            for (int k = 0; k < NUM_CH; k++) begin
                c = (m_ptr + k) % NUM_CH;
                if (!found && !emp[c[CH_W-1:0]]) begin
                    found = 1'b1;
                    pc    = c;
                end
            end
        end
        if (found) exp_rd = NUM_CH'(1) << pc;

        #1;
        check_val("x_rd_en", 64'(x_rd_en), 64'(exp_rd));
        check_val("y_wr_en", 64'(y_wr_en), 64'(m_hold && !full));
        check_val("y_out",   64'(y_out),   m_hold ? 64'(m_data) : 64'd0);
        check_val("y_ch",    64'(y_ch),    m_hold ? 64'(m_ch)   : 64'd0);
        for (int i = 0; i < NUM_CH; i++) begin
            check_val($sformatf("ch_count%0d", i),
                      64'((ch_count >> (i * CNT_SIZE)) & CNT_MASK),
                      64'(m_cnt[i] % (1 << CNT_SIZE)));
        end
        if (y_wr_en === 1'b1) begin
            exp_sb = (sb[y_ch].size() > 0) ? 64'(sb[y_ch].pop_front()) : 64'bx;
            check_val("sb_order", 64'(y_out), exp_sb);
        end

        @(posedge clock);
        if (!rst) begin
            if (m_hold) begin
                if (!full) begin
                    m_cnt[m_ch]++;
                    m_ptr  = (m_ch + 1) % NUM_CH;
                    m_hold = 1'b0;
                end
            end else if (found) begin
                m_hold = 1'b1;
                m_data = head[pc];
                m_ch   = pc;
                sb[pc].push_back(head[pc]);
                if (rand_heads) head[pc] = $urandom;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rand_heads = 1'b0;
        reset      = 1'b1;
        x_empty    = '1;
        y_out_full = 1'b0;
        x_in       = '0;
        for (int i = 0; i < NUM_CH; i++) head[i] = '0;
        model_clear();
        @(negedge clock);

        // Reset state; no pop during reset even with data available.
        run_cycle(2'b11, 1'b0, 1'b1);
        run_cycle(2'b00, 1'b0, 1'b1);

        // Both channels always ready: 0x11/ch0, 0x22/ch1 alternating, push every 2nd cycle.
        head[0] = 32'h0000_0011;
        head[1] = 32'h0000_0022;
        repeat (8) run_cycle(2'b00, 1'b0, 1'b0);

        // Only ch1 ready from a fresh reset: all writes tagged ch1, ch0 count stays 0.
        run_cycle(2'b11, 1'b0, 1'b1);
        repeat (10) run_cycle(2'b01, 1'b0, 1'b0);

        // Backpressure: 0xDEADBEEF held through 5 full cycles, then one write.
        repeat (2) run_cycle(2'b11, 1'b0, 1'b0);
        head[0] = 32'hDEAD_BEEF;
        run_cycle(2'b10, 1'b0, 1'b0);
        repeat (5) run_cycle(2'b00, 1'b1, 1'b0);
        run_cycle(2'b11, 1'b0, 1'b0);

        // Reset while holding a ch1 sample: no write, next pick is ch0.
        head[0] = 32'h0000_C0DE;
        head[1] = 32'h5A5A_5A5A;
        run_cycle(2'b01, 1'b0, 1'b0);
        run_cycle(2'b00, 1'b0, 1'b1);
        run_cycle(2'b00, 1'b0, 1'b0);
        run_cycle(2'b00, 1'b0, 1'b0);

        // Counter wrap: 2^CNT_SIZE ch0 samples bring ch_count[0] back to 0.
        run_cycle(2'b11, 1'b0, 1'b1);
        rand_heads = 1'b1;
        repeat (2 * (1 << CNT_SIZE)) run_cycle(2'b10, 1'b0, 1'b0);
        check_val("wrap_ch0", 64'(ch_count[CNT_SIZE-1:0]), 64'd0);

        // Random empty/full patterns with occasional resets.
        for (int i = 0; i < 10000; i++) begin
            run_cycle(NUM_CH'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
